// File: rtl/issue_ctrl.sv
// In-order issue stage controller: register scoreboard, single outstanding
// memory op, jump wait state and a saturating stall counter.
module issue_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_valid,
    input  logic [3:0]  ra_a,
    input  logic [3:0]  ra_b,
    input  logic [3:0]  ra_m,
    input  logic [3:0]  ra_d,
    input  logic        is_mem,
    input  logic        mem_write,
    input  logic        is_jump,
    input  logic        wb_valid,
    input  logic [3:0]  wb_reg,
    input  logic        mem_done,
    input  logic        jump_resolve,
    output logic        dec_ready,
    output logic        iss_valid,
    output logic [3:0]  iss_tag,
    output logic [15:0] busy,
    output logic [7:0]  stall_cnt
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_JWAIT = 1'b1;

    logic        state_r;
    logic        state_nxt_s;
    logic        mem_pend_r;
    logic        mem_pend_nxt_s;
    logic [15:0] busy_r;
    logic [15:0] busy_nxt_s;
    logic        iss_valid_r;
    logic [3:0]  iss_tag_r;
    logic [7:0]  stall_cnt_r;
    logic        hazard_s;
    logic        ready_s;
    logic        accept_s;

    // Hazard detection reads only registered scoreboard state (no writeback bypass).
    always_comb begin
        hazard_s = ((ra_a != 4'd0) && busy_r[ra_a]) ||
                   ((ra_b != 4'd0) && busy_r[ra_b]) ||
                   ((ra_m != 4'd0) && busy_r[ra_m]) ||
                   ((ra_d != 4'd0) && busy_r[ra_d]);
        ready_s  = !rst && (state_r == ST_RUN) && !hazard_s && !(is_mem && mem_pend_r);
        accept_s = dec_valid && ready_s;
    end

    // Scoreboard update: writeback clear and issue set may hit different registers together.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wb_valid && (wb_reg != 4'd0)) begin
            busy_nxt_s[wb_reg] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (accept_s && (ra_d != 4'd0) && !(is_mem && mem_write)) begin
            busy_nxt_s[ra_d] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Memory-pending flag and jump-wait state transitions.
    always_comb begin
        if (accept_s && is_mem) begin
            mem_pend_nxt_s = 1'b1;
        end else if (mem_done) begin
            mem_pend_nxt_s = 1'b0;
        end else begin
            mem_pend_nxt_s = mem_pend_r;
        end
        case (state_r)
            ST_RUN: begin
                if (accept_s && is_jump) begin
                    state_nxt_s = ST_JWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_JWAIT: begin
                if (jump_resolve) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_JWAIT;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_RUN;
            mem_pend_r  <= 1'b0;
            busy_r      <= 16'h0000;
            iss_valid_r <= 1'b0;
            iss_tag_r   <= 4'd0;
            stall_cnt_r <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            mem_pend_r  <= mem_pend_nxt_s;
            busy_r      <= busy_nxt_s;
            iss_valid_r <= accept_s;
            if (accept_s) begin
                iss_tag_r <= ra_d;
            end
            if (dec_valid && !ready_s && (stall_cnt_r != 8'd255)) begin
                stall_cnt_r <= stall_cnt_r + 8'd1;
            end
        end
    end

    assign dec_ready = ready_s;
    assign iss_valid = iss_valid_r;
    assign iss_tag   = iss_tag_r;
    assign busy      = busy_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
- REQ-001: clk  in  1  sole clock; all state updates on rising edge.
- REQ-002: rst  in  1  reset, synchronous, active-high.
- REQ-003: dec_valid  in  1  decoded instruction present at issue stage.
- REQ-004: ra_a, ra_b, ra_m  in  4 each  source register addresses; 0 = unused/zero register.
- REQ-005: ra_d  in  4  destination register address; 0 = no write.
- REQ-006: is_mem, mem_write, is_jump  in  1 each  decoded class flags.
- REQ-007: wb_valid  in  1, wb_reg  in  4  writeback retiring a pending destination.
- REQ-008: mem_done  in  1  outstanding memory op complete.
- REQ-009: jump_resolve  in  1  outstanding jump resolved.
- REQ-010: dec_ready  out  1  combinational; instruction accepted this cycle when dec_valid & dec_ready.
- REQ-011: iss_valid  out  1  registered issue strobe to execute.
- REQ-012: iss_tag  out  4  registered ra_d of issued instruction.
- REQ-013: busy  out  16  scoreboard, bit n = write to register n pending.
- REQ-014: stall_cnt  out  8  saturating count of cycles with dec_valid & ~dec_ready.

Function
- REQ-015: States RUN and JWAIT; plus independent flag mem_pend.
- REQ-016: Hazard = any nonzero source among ra_a, ra_b, ra_m with busy bit set, or nonzero ra_d with busy bit set (WAW).
- REQ-017: dec_ready = state RUN & ~hazard & ~(is_mem & mem_pend); evaluated from registered busy/mem_pend only (no same-cycle writeback bypass).
- REQ-018: dec_ready shall be 0 while rst is high.
- REQ-019: On accept: iss_valid=1 and iss_tag=ra_d next cycle; otherwise iss_valid=0 next cycle, iss_tag holds.
- REQ-020: On accept with ra_d != 0, busy[ra_d] set next cycle.
- REQ-021: On wb_valid with wb_reg != 0, busy[wb_reg] cleared next cycle; wb_reg == 0 or non-busy bit ignored.
- REQ-022: Same-cycle accept setting reg X and writeback clearing reg Y: both apply; X == Y impossible by REQ-016.
- REQ-023: busy[0] always 0.
- REQ-024: On accept with is_mem, mem_pend set next cycle; mem_done clears it; mem_done with mem_pend=0 ignored.
- REQ-025: Stores (mem_write) require ra_d == 0 and set no busy bit; loads set busy[ra_d] per REQ-020.
- REQ-026: On accept with is_jump, RUN -> JWAIT; JWAIT -> RUN on jump_resolve; jump_resolve in RUN ignored.
- REQ-027: In JWAIT no instruction accepted; writebacks and mem_done still processed.
- REQ-028: stall_cnt increments by 1 each cycle with dec_valid & ~dec_ready, holds at 255.
- REQ-029: Accept-to-iss_valid latency exactly 1 cycle; back-to-back independent instructions issue every cycle.

Reset
- REQ-030: On rst: state RUN, busy=0, mem_pend=0, iss_valid=0, iss_tag=0, stall_cnt=0 next cycle.
- REQ-031: rst mid-operation discards pending writes, memory op and jump wait; subsequent wb_valid/mem_done/jump_resolve for discarded ops treated per REQ-021/024/026 ignore rules.

Verification
- REQ-032: Issue ra_d=5, next instr ra_a=5 -> second stalls (dec_ready=0, stall_cnt increments) until cycle after wb_valid wb_reg=5, then issues with iss_valid=1.
- REQ-033: Three consecutive instrs ra_d=1,2,3 no sources -> iss_valid high 3 consecutive cycles, iss_tag 1,2,3, busy=0x000E.
- REQ-034: Load is_mem ra_d=4, then store is_mem mem_write ra_m=6 -> store blocked until cycle after mem_done; busy[4] set.
- REQ-035: Jump accepted -> dec_ready=0 in JWAIT for 10 cycles with dec_valid, stall_cnt=10; jump_resolve -> next instruction accepted following cycle.
- REQ-036: busy=0x0030, mem_pend=1, JWAIT, rst pulsed 1 cycle -> busy=0, mem_pend=0, RUN, iss_valid=0; instr ra_a=4 issues immediately after.
- REQ-037: Hold dec_valid with permanent hazard 300 cycles -> stall_cnt saturates at 255.
